// File: rtl/bs_decoder.sv
// bs_decoder -- receive-side USB bit-unstuffer and PID checker.
// Sits between the NRZI decoder and the receive CRC checker. One serial bit
// is consumed per clock. Stuffed zeros are dropped, the PID is checked, and
// each payload bit after the PID is qualified for the CRC unit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_decode
// PID   | shifting in the PID bits, LSB first
// DATA  | forwarding payload bits and dropping stuffed bits
// DONE  | one cycle after end_decode, then back to IDLE
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_decode  one-cycle pulse with the first PID bit on s_in
//   end_decode    one-cycle pulse the cycle after the last packet bit
//   s_in          serial bit from the NRZI decoder
//   rc_PIDerror   synchronous clear of PID_error
//   s_out         registered copy of the last accepted bit
//   start_rc_crc  s_out carries a valid payload bit for the CRC unit
//   end_rc_crc    one-cycle end-of-packet pulse
//   PID_error     sticky PID check failure (or truncated PID)
module bs_decoder #(
  parameter int PID_BITS  = 8,
  parameter int STUFF_RUN = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_decode,
  input  logic end_decode,
  input  logic s_in,
  input  logic rc_PIDerror,
  output logic s_out,
  output logic start_rc_crc,
  output logic end_rc_crc,
  output logic PID_error
);

  localparam int CW   = $clog2(PID_BITS + 1);
  localparam int OW   = $clog2(STUFF_RUN + 1);
  localparam int HALF = PID_BITS / 2;
  localparam logic [CW-1:0] LAST_PID = CW'(PID_BITS - 1);
  localparam logic [OW-1:0] RUN_MAX  = OW'(STUFF_RUN);

  typedef enum logic [1:0] {IDLE, PID, DATA, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [OW-1:0]       ones_cnt, ones_cnt_nxt, ones_inc;
  logic [PID_BITS-1:0] pid_sr, pid_sr_nxt, pid_full;
  logic                pid_ok, pid_ok_nxt;
  logic                pid_valid;
  logic                s_out_nxt, crc_nxt, end_nxt, err_nxt;

  // PID register with the current bit merged in at its arrival position.
  assign pid_full  = pid_sr | (PID_BITS'(s_in) << bit_cnt);
  assign pid_valid = (pid_full[HALF-1:0] == ~pid_full[PID_BITS-1:HALF]);

  // Saturating so a malformed PID with a long run of ones cannot wrap.
  assign ones_inc = (ones_cnt == RUN_MAX) ? ones_cnt : ones_cnt + OW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      ones_cnt     <= '0;
      pid_sr       <= '0;
      pid_ok       <= 1'b0;
      s_out        <= 1'b0;
      start_rc_crc <= 1'b0;
      end_rc_crc   <= 1'b0;
      PID_error    <= 1'b0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      ones_cnt     <= ones_cnt_nxt;
      pid_sr       <= pid_sr_nxt;
      pid_ok       <= pid_ok_nxt;
      s_out        <= s_out_nxt;
      start_rc_crc <= crc_nxt;
      end_rc_crc   <= end_nxt;
      PID_error    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    ones_cnt_nxt = ones_cnt;
    pid_sr_nxt   = pid_sr;
    pid_ok_nxt   = pid_ok;
    s_out_nxt    = s_out;
    crc_nxt      = 1'b0;
    end_nxt      = 1'b0;
    // Set conditions below override this clear.
    err_nxt      = PID_error & ~rc_PIDerror;

    if (start_decode) begin
      // Start (or restart) a packet: s_in is PID bit 0.
      state_nxt    = PID;
      bit_cnt_nxt  = CW'(1);
      ones_cnt_nxt = OW'(s_in);
      pid_sr_nxt   = PID_BITS'(s_in);
      pid_ok_nxt   = 1'b0;
      s_out_nxt    = s_in;
      err_nxt      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        PID: begin
          if (end_decode) begin
            // Truncated PID.
            state_nxt = DONE;
            end_nxt   = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            s_out_nxt    = s_in;
            pid_sr_nxt   = pid_full;
            bit_cnt_nxt  = bit_cnt + CW'(1);
            ones_cnt_nxt = s_in ? ones_inc : '0;
            if (bit_cnt == LAST_PID) begin
              state_nxt  = DATA;
              pid_ok_nxt = pid_valid;
              if (!pid_valid) err_nxt = 1'b1;
            end
          end
        end
        DATA: begin
          if (end_decode) begin
            state_nxt = DONE;
            end_nxt   = 1'b1;
          end else if (ones_cnt == RUN_MAX) begin
            // Stuffed bit (or stuffing violation): dropped, s_out held.
            ones_cnt_nxt = '0;
          end else begin
            s_out_nxt    = s_in;
            crc_nxt      = pid_ok;
            ones_cnt_nxt = s_in ? ones_inc : '0;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bs_decoder.sv
// Self-checking bench for bs_decoder: table of directed packets, hand-written
// corner sequences, and randomized packets checked against a packet-level
// reference model of the unstuffing / PID rules.
module tb_bs_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic start_decode, end_decode, s_in, rc_PIDerror;
  logic s_out, start_rc_crc, end_rc_crc, PID_error;

  int   checks = 0;
  int   errors = 0;
  logic exp_sout = 1'b0;

  bs_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_decode (start_decode),
    .end_decode   (end_decode),
    .s_in         (s_in),
    .rc_PIDerror  (rc_PIDerror),
    .s_out        (s_out),
    .start_rc_crc (start_rc_crc),
    .end_rc_crc   (end_rc_crc),
    .PID_error    (PID_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pid;      // pid[i] = i-th arriving PID bit
    int          nd;
    logic [31:0] data;     // data[i] = i-th arriving payload bit
    logic        exp_err;
    int          exp_nvalid;
    logic        exp_last;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit pid_is_valid(input logic [7:0] p);
    int lo = 0;
    int hi = 0;
    for (int i = 0; i < 4; i++) begin
      lo += int'(p[i]) << i;
      hi += int'(p[i+4]) << i;
    end
    return (lo + hi) == 15 && ((lo ^ hi) == 15);
  endfunction

  function automatic int max_run(input logic [7:0] p);
    int run = 0;
    int best = 0;
    for (int i = 0; i < 8; i++) begin
      run = p[i] ? run + 1 : 0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  // Sends PID + payload; every cycle's outputs are compared against the model.
  task automatic send_packet(input logic [7:0] pid, input int nd, input logic [31:0] data,
                             input bit rc_last, input bit do_end, output int nvalid);
    bit   valid;
    int   run;
    logic b, exp_crc, exp_err;
    valid  = pid_is_valid(pid);
    run    = 0;
    nvalid = 0;
    for (int i = 0; i < 8 + nd; i++) begin
      b            = (i < 8) ? pid[i] : data[i-8];
      start_decode = (i == 0);
      end_decode   = 1'b0;
      s_in         = b;
      rc_PIDerror  = (i == 7) && rc_last;
      tick();
      if (i < 8) begin
        exp_sout = b;
        exp_crc  = 1'b0;
        run      = b ? run + 1 : 0;
      end else if (run == 6) begin
        exp_crc = 1'b0;
        run     = 0;
      end else begin
        exp_sout = b;
        exp_crc  = valid;
        run      = b ? run + 1 : 0;
      end
      exp_err = (i >= 7) && !valid;
      check("s_out", s_out, exp_sout);
      check("start_rc_crc", start_rc_crc, exp_crc);
      check("end_rc_crc_low", end_rc_crc, 0);
      check("PID_error", PID_error, exp_err);
      nvalid += int'(start_rc_crc);
    end
    start_decode = 1'b0;
    rc_PIDerror  = 1'b0;
    if (do_end) begin
      end_decode = 1'b1;
      s_in       = ~s_in;
      tick();
      check("end_pulse", end_rc_crc, 1);
      check("end_crc_low", start_rc_crc, 0);
      check("end_sout_hold", s_out, exp_sout);
      end_decode = 1'b0;
      tick();
      check("end_pulse_once", end_rc_crc, 0);
      check("done_crc_low", start_rc_crc, 0);
      check("done_err", PID_error, !valid);
    end
  endtask

  vec_t vecs[6];
  int   nv;
  logic [7:0] rp;

  initial begin
    vecs[0] = '{pid: 8'hC3, nd: 4, data: 32'h0000000D, exp_err: 1'b0, exp_nvalid: 4, exp_last: 1'b1};
    vecs[1] = '{pid: 8'hF5, nd: 4, data: 32'h0000000D, exp_err: 1'b1, exp_nvalid: 0, exp_last: 1'b1};
    vecs[2] = '{pid: 8'h3C, nd: 9, data: 32'h0000013F, exp_err: 1'b0, exp_nvalid: 8, exp_last: 1'b1};
    vecs[3] = '{pid: 8'hC3, nd: 6, data: 32'h0000002F, exp_err: 1'b0, exp_nvalid: 5, exp_last: 1'b1};
    vecs[4] = '{pid: 8'h3C, nd: 8, data: 32'h0000007F, exp_err: 1'b0, exp_nvalid: 7, exp_last: 1'b0};
    vecs[5] = '{pid: 8'h0F, nd: 0, data: 32'h00000000, exp_err: 1'b0, exp_nvalid: 0, exp_last: 1'b0};

    rst_n = 1'b0; start_decode = 1'b0; end_decode = 1'b0; s_in = 1'b0; rc_PIDerror = 1'b0;
    #12;
    check("rst_s_out", s_out, 0);
    check("rst_crc", start_rc_crc, 0);
    check("rst_end", end_rc_crc, 0);
    check("rst_err", PID_error, 0);
    rst_n = 1'b1;

    // Idle: toggling s_in and stray end_decode do nothing.
    for (int i = 0; i < 10; i++) begin
      s_in       = 1'($urandom);
      end_decode = (i % 3 == 0);
      tick();
      check("idle_crc", start_rc_crc, 0);
      check("idle_end", end_rc_crc, 0);
      check("idle_sout", s_out, 0);
    end
    end_decode = 1'b0;

    // Directed table.
    foreach (vecs[k]) begin
      send_packet(vecs[k].pid, vecs[k].nd, vecs[k].data, 1'b0, 1'b1, nv);
      check("tbl_nvalid", nv, vecs[k].exp_nvalid);
      check("tbl_err", PID_error, vecs[k].exp_err);
      check("tbl_last", s_out, vecs[k].exp_last);
      // Back in IDLE: end_decode is ignored.
      end_decode = 1'b1;
      tick();
      check("tbl_idle_end", end_rc_crc, 0);
      end_decode = 1'b0;
    end

    // rc_PIDerror clears the sticky flag on the next edge.
    send_packet(8'hF5, 2, 32'h1, 1'b0, 1'b1, nv);
    rc_PIDerror = 1'b1;
    tick();
    check("rc_clear", PID_error, 0);
    rc_PIDerror = 1'b0;

    // Set wins over a coincident clear.
    send_packet(8'hF5, 1, 32'h0, 1'b1, 1'b1, nv);
    check("set_wins", PID_error, 1);

    // Truncated PID.
    start_decode = 1'b1; s_in = 1'b1;
    tick();
    start_decode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_in = 1'(i);
      tick();
    end
    check("trunc_err_pre", PID_error, 0);
    end_decode = 1'b1;
    tick();
    check("trunc_end", end_rc_crc, 1);
    check("trunc_err", PID_error, 1);
    end_decode = 1'b0;
    tick();
    check("trunc_done", end_rc_crc, 0);

    // Restart during DATA with ones pending, then a fresh packet.
    send_packet(8'hC3, 3, 32'h7, 1'b0, 1'b0, nv);
    send_packet(8'h3C, 9, 32'h13F, 1'b0, 1'b1, nv);
    check("restart_nvalid", nv, 8);

    // Asynchronous reset mid-packet.
    send_packet(8'h3C, 2, 32'h3, 1'b0, 1'b0, nv);
    check("pre_rst_crc", start_rc_crc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sout", s_out, 0);
    check("arst_crc", start_rc_crc, 0);
    check("arst_end", end_rc_crc, 0);
    check("arst_err", PID_error, 0);
    tick();
    rst_n    = 1'b1;
    exp_sout = 1'b0;
    send_packet(8'hC3, 4, 32'hD, 1'b0, 1'b1, nv);
    check("post_rst_nvalid", nv, 4);

    // Randomized packets.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        rp[3:0] = 4'($urandom);
        rp[7:4] = ~rp[3:0];
      end else begin
        rp = 8'($urandom);
        while (pid_is_valid(rp) || max_run(rp) >= 6) rp = 8'($urandom);
      end
      send_packet(rp, int'($urandom_range(24, 0)), $urandom, 1'($urandom), 1'b1, nv);
      if ($urandom_range(3, 0) == 0) begin
        rc_PIDerror = 1'b1;
        tick();
        check("rand_rc_clear", PID_error, 0);
        rc_PIDerror = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
